// File: rtl/avg4_sequencer.sv
// Control sequencer for the 4-point averaging filter: steps the shared register
// file / ALU through load, window shift, accumulate and divide for each sample.
//
// state  | meaning
// IDLE   | waiting for a sample start
// LOAD   | R0 <= input sample, bump sample count
// SH4    | R4 <= R3
// SH3    | R3 <= R2
// SH2    | R2 <= R1
// SH1    | R1 <= R0; leave early until the window is full
// SUM1   | R5 <= R1 + R2
// SUM2   | R5 <= R5 + R3
// SUM3   | R5 <= R5 + R4
// DIV    | R7 <= R5 >>> 2
// DONE   | out_valid pulse, R7 holds the new average
// ERROR  | accumulate overflowed; wait for the next start
module avg4_sequencer #(
   parameter int OP_W   = 3,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              data_ready,
   input  logic              overflow,
   output logic [OP_W-1:0]   op,
   output logic [ADDR_W-1:0] src1,
   output logic [ADDR_W-1:0] src2,
   output logic [ADDR_W-1:0] dest,
   output logic              modwait,
   output logic              out_valid,
   output logic              err,
   output logic              overrun
);

   typedef enum logic [3:0] {
      S_IDLE, S_LOAD, S_SH4, S_SH3, S_SH2, S_SH1,
      S_SUM1, S_SUM2, S_SUM3, S_DIV, S_DONE, S_ERROR
   } state_t;

   localparam logic [OP_W-1:0] OP_NOP  = OP_W'(0);
   localparam logic [OP_W-1:0] OP_COPY = OP_W'(1);
   localparam logic [OP_W-1:0] OP_LOAD = OP_W'(2);
   localparam logic [OP_W-1:0] OP_ADD  = OP_W'(3);
   localparam logic [OP_W-1:0] OP_SHR2 = OP_W'(5);

   state_t       state, state_n;
   logic [2:0]   count, count_n;
   logic         pending, pending_n;
   logic         dr_d;
   logic         start, busy, overrun_n;
   logic [OP_W-1:0]   op_n;
   logic [ADDR_W-1:0] src1_n, src2_n, dest_n;

   always_comb begin
      start     = data_ready & ~dr_d;
      busy      = (state != S_IDLE) && (state != S_ERROR);
      state_n   = state;
      count_n   = count;
      pending_n = pending;
      overrun_n = 1'b0;
      case (state)
         S_IDLE, S_ERROR: if (start) state_n = S_LOAD;
         S_LOAD: begin
            state_n = S_SH4;
            if (count != 3'd4) count_n = count + 3'd1;
         end
         S_SH4:  state_n = S_SH3;
         S_SH3:  state_n = S_SH2;
         S_SH2:  state_n = S_SH1;
         S_SH1: begin
            if (count == 3'd4)          state_n = S_SUM1;
            else if (pending || start)  state_n = S_LOAD;
            else                        state_n = S_IDLE;
         end
         S_SUM1: state_n = overflow ? S_ERROR : S_SUM2;
         S_SUM2: state_n = overflow ? S_ERROR : S_SUM3;
         S_SUM3: state_n = overflow ? S_ERROR : S_DIV;
         S_DIV:  state_n = S_DONE;
         S_DONE: state_n = (pending || start) ? S_LOAD : S_IDLE;
         default: state_n = S_IDLE;
      endcase

      // A restart consumes the pending slot; a start arriving on that same
      // cycle while a request was already queued refills the slot.
      if (busy) begin
         if (state_n == S_LOAD) begin
            pending_n = pending & start;
         end else if (start) begin
            if (pending) overrun_n = 1'b1;
            else         pending_n = 1'b1;
         end
      end
      if (state_n == S_ERROR) pending_n = 1'b0;
   end

   always_comb begin
      op_n   = OP_NOP;
      src1_n = '0;
      src2_n = '0;
      dest_n = '0;
      case (state_n)
         S_LOAD: begin op_n = OP_LOAD; dest_n = ADDR_W'(0); end
         S_SH4:  begin op_n = OP_COPY; src1_n = ADDR_W'(3); dest_n = ADDR_W'(4); end
         S_SH3:  begin op_n = OP_COPY; src1_n = ADDR_W'(2); dest_n = ADDR_W'(3); end
         S_SH2:  begin op_n = OP_COPY; src1_n = ADDR_W'(1); dest_n = ADDR_W'(2); end
         S_SH1:  begin op_n = OP_COPY; src1_n = ADDR_W'(0); dest_n = ADDR_W'(1); end
         S_SUM1: begin op_n = OP_ADD; src1_n = ADDR_W'(1); src2_n = ADDR_W'(2); dest_n = ADDR_W'(5); end
         S_SUM2: begin op_n = OP_ADD; src1_n = ADDR_W'(5); src2_n = ADDR_W'(3); dest_n = ADDR_W'(5); end
         S_SUM3: begin op_n = OP_ADD; src1_n = ADDR_W'(5); src2_n = ADDR_W'(4); dest_n = ADDR_W'(5); end
         S_DIV:  begin op_n = OP_SHR2; src1_n = ADDR_W'(5); dest_n = ADDR_W'(7); end
         default: ;
      endcase
   end

   // Outputs are registered from the next-state decode so they line up with state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         count     <= 3'd0;
         pending   <= 1'b0;
         dr_d      <= 1'b0;
         op        <= OP_NOP;
         src1      <= '0;
         src2      <= '0;
         dest      <= '0;
         modwait   <= 1'b0;
         out_valid <= 1'b0;
         err       <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         state     <= state_n;
         count     <= count_n;
         pending   <= pending_n;
         dr_d      <= data_ready;
         op        <= op_n;
         src1      <= src1_n;
         src2      <= src2_n;
         dest      <= dest_n;
         modwait   <= (state_n != S_IDLE) && (state_n != S_ERROR);
         out_valid <= (state_n == S_DONE);
         err       <= (state_n == S_ERROR);
         overrun   <= overrun_n;
      end
   end

endmodule

// File: doc/avg4_sequencer.md
Name: avg4_sequencer

Overview:
- Moore-style sequencer for the shared 8-entry register file and ALU datapath of the 4-point averaging filter.
- Per accepted sample it drives the datapath through this sequence:
  - load the sample;
  - shift the 4-deep sample window;
  - accumulate the window;
  - divide by 4 and flag the result valid.
- Handshakes with the sample source (data_ready / modwait) and traps datapath overflow into an error state.

Parameters:
- OP_W, 3, width of the datapath opcode bus.
- ADDR_W, 3, width of each register-file select (8 registers).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  reset; synchronous, active-high.
- data_ready  input  1  sample source has a sample on the datapath input; level signal, start is its rising edge.
- overflow  input  1  datapath ALU overflow, combinational from the current cycle's op.
- op  output  OP_W  datapath opcode: 000 NOP, 001 COPY (dest<=src1), 010 LOAD (dest<=input), 011 ADD (dest<=src1+src2), 101 SHR2 (dest<=src1>>>2).
- src1  output  ADDR_W  ALU operand 1 register select.
- src2  output  ADDR_W  ALU operand 2 register select.
- dest  output  ADDR_W  destination register select; ignored when op=NOP.
- modwait  output  1  registered busy indication to the sample source.
- out_valid  output  1  one-cycle pulse: R7 holds a new average.
- err  output  1  high while in ERROR.
- overrun  output  1  one-cycle pulse: a start was dropped.

Behaviour:
- Register map:
  - R0: input latch.
  - R1..R4: window, with R1 the newest.
  - R5: accumulator.
  - R7: result.
- Start detection:
  - dr_d is data_ready registered.
  - start = data_ready & ~dr_d.
- States, one cycle each except IDLE and ERROR. op/src1/src2/dest are decoded from the state:
  - IDLE: NOP. On start go to LOAD.
  - LOAD: LOAD, dest=0. Sample count increments, saturating at 4.
  - SH4: COPY 3->4.
  - SH3: COPY 2->3.
  - SH2: COPY 1->2.
  - SH1: COPY 0->1. If count<4 go to IDLE; otherwise go to SUM1.
  - SUM1: ADD 1+2->5.
  - SUM2: ADD 5+3->5.
  - SUM3: ADD 5+4->5.
  - DIV: SHR2 5->7.
  - DONE: NOP, out_valid=1, then go to IDLE. If a start is pending, go directly to LOAD instead.
  - ERROR: NOP, err=1. On start go to LOAD; the error clears.
- Overflow:
  - overflow=1 during SUM1, SUM2 or SUM3 sends the next state to ERROR. The sequence aborts and R7 is not updated.
  - overflow is ignored in all other states.
- Latency and modwait:
  - With start in cycle t: LOAD is at t+1 and the DONE/out_valid pulse at t+10.
  - modwait=1 from t+1 through t+10. modwait is 0 in IDLE and ERROR.
- Start while busy (state not IDLE/ERROR):
  - A 1-deep pending flag is set.
  - A further start while the flag is already set is dropped and overrun pulses for 1 cycle.
  - The pending flag is consumed on the DONE->LOAD or SH1->LOAD transition (SH1 with count<4 goes to LOAD if pending).
  - The pending flag is cleared on entry to ERROR.
- Count:
  - Counts 0..4 and saturates at 4.
  - Cleared only by reset; ERROR does not clear it.
- Reset (any cycle, including mid-sequence), next edge:
  - state=IDLE; count=0; pending=0; dr_d=0.
  - modwait=0, out_valid=0, err=0, overrun=0.
  - op=000, src1/src2/dest=0.
- Edge case: if data_ready is already high when reset is released, that counts as a start on the first cycle (dr_d=0).

Test Plan:
- Reset, then 4 isolated data_ready pulses 20 cycles apart:
  - Samples 1-3: no SUM states, no out_valid, modwait high 5 cycles each.
  - Sample 4: out_valid at t+10, op trace LOAD, COPY x4, ADD x3, SHR2.
- data_ready held high for 30 cycles after 4 samples are loaded -> exactly one sequence, no restart, no overrun.
- Overflow=1 in SUM2:
  - Next state ERROR, err=1, no out_valid, modwait=0.
  - Next start -> LOAD, err=0, and the full sequence completes.
- Second start at t+3 -> pending; DONE at t+10 goes to LOAD at t+11; second out_valid at t+20.
- Starts at t+3 and t+5 -> overrun pulse at t+6, only one extra sequence runs.
- Reset asserted in SUM1 -> next cycle all outputs 0; a following start needs 4 fresh samples before any out_valid.
